// File: rtl/syn_accum_unit.sv
// Synaptic accumulator: sums weighted spikes into one neuron's membrane voltage per timestep.
// Latency: syn_en at edge t lands in cur_voltage at edge t+1; one add per cycle, back-to-back allowed.
// Backpressure: none; spikes are accepted every ACCU cycle and silently ignored in all other states.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   clr                 synchronous clear to V_REST (beats every input except rst)
//   step_start          begin a timestep (IDLE only)
//   step_end            close accumulation (ACCU only)
//   syn_en, weight      spike strobe and its synaptic weight (ACCU only)
//   cur_voltage         registered membrane voltage
//   sat                 sticky saturation flag for the current step
//   busy, done          not-IDLE indicator, one-cycle completion pulse
module syn_accum_unit #(
    parameter int                  W_WIDTH    = 4,
    parameter int                  V_WIDTH    = 8,
    parameter int                  SIGNED_W   = 0,
    parameter int                  LEAK_SHIFT = 1,
    parameter logic [V_WIDTH-1:0]  V_REST     = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               step_start,
    input  logic               step_end,
    input  logic               syn_en,
    input  logic [W_WIDTH-1:0] weight,
    output logic [V_WIDTH-1:0] cur_voltage,
    output logic               sat,
    output logic               busy,
    output logic               done
);

    // One guard bit above the voltage so the add can never wrap before clamping.
    localparam int XW = V_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCU  = 3'd1,
        S_DRAIN = 3'd2,
        S_DECAY = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Stage 1: registered spike
    logic               s1_vld;
    logic [W_WIDTH-1:0] s1_w;

    // Stage 2 arithmetic
    logic [XW-1:0]      w_ext;
    logic [XW-1:0]      v_ext;
    logic [XW-1:0]      sum;
    logic               ovf;
    logic [V_WIDTH-1:0] clamp_v;
    logic [V_WIDTH-1:0] add_v;
    logic [V_WIDTH-1:0] leak_amt;
    logic [V_WIDTH-1:0] leak_v;

    logic accept_spike;
    logic start_step;

    assign accept_spike = (state == S_ACCU) && syn_en;
    assign start_step   = (state == S_IDLE) && step_start;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (step_start) state_nxt = S_ACCU;
                S_ACCU:  if (step_end)   state_nxt = S_DRAIN;
                // With no leak configured the decay cycle is skipped entirely.
                S_DRAIN: state_nxt = (LEAK_SHIFT > 0) ? S_DECAY : S_DONE;
                S_DECAY: state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        if (state != S_IDLE) begin
            busy = 1'b1;
        end
        if (state == S_DONE) begin
            done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture the spike. Only ACCU loads a valid, so the valid
    // captured on the step_end edge is the last one retired in DRAIN.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld <= 1'b0;
            s1_w   <= '0;
        end else if (clr) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= accept_spike;
            if (accept_spike) begin
                s1_w <= weight;
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand extension, overflow detection and leak, per number format
    // ------------------------------------------------------------------
    generate
        if (SIGNED_W != 0) begin : g_signed
            assign w_ext    = {{(XW-W_WIDTH){s1_w[W_WIDTH-1]}}, s1_w};
            assign v_ext    = {cur_voltage[V_WIDTH-1], cur_voltage};
            // Guard bit disagreeing with the sign bit means the result left range.
            assign ovf      = sum[XW-1] ^ sum[XW-2];
            assign clamp_v  = sum[XW-1] ? {1'b1, {(V_WIDTH-1){1'b0}}}
                                        : {1'b0, {(V_WIDTH-1){1'b1}}};
            assign leak_amt = $signed(cur_voltage) >>> LEAK_SHIFT;
        end else begin : g_unsigned
            assign w_ext    = {{(XW-W_WIDTH){1'b0}}, s1_w};
            assign v_ext    = {1'b0, cur_voltage};
            // Weights are non-negative, so only the top end can be exceeded.
            assign ovf      = sum[XW-1];
            assign clamp_v  = '1;
            assign leak_amt = cur_voltage >> LEAK_SHIFT;
        end
    endgenerate

    assign sum    = v_ext + w_ext;
    assign add_v  = ovf ? clamp_v : sum[V_WIDTH-1:0];
    // v - (v >> k) stays between 0 and v (or v and 0), so it cannot overflow.
    assign leak_v = cur_voltage - leak_amt;

    // ------------------------------------------------------------------
    // Stage 2: membrane voltage and sticky saturation
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_voltage <= '0;
            sat         <= 1'b0;
        end else if (clr) begin
            cur_voltage <= V_REST;
            sat         <= 1'b0;
        end else begin
            if (start_step) begin
                sat <= 1'b0;
            end
            // s1_vld is only ever set in ACCU/DRAIN, never together with DECAY.
            if (s1_vld) begin
                cur_voltage <= add_v;
                if (ovf) begin
                    sat <= 1'b1;
                end
            end else if (state == S_DECAY) begin
                cur_voltage <= leak_v;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sanity properties
    // ------------------------------------------------------------------
    a_done_busy: assert property (@(posedge clk) disable iff (!rst) done |-> busy);
    a_done_one:  assert property (@(posedge clk) disable iff (!rst) done |=> !done);
    a_no_add_in_decay: assert property (@(posedge clk) disable iff (!rst)
                                        (state == S_DECAY) |-> !s1_vld);

endmodule

// File: tb/tb_syn_accum_unit.sv
module tb_syn_accum_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       step_start = 1'b0;
    logic       step_end = 1'b0;
    logic       syn_en = 1'b0;
    logic [3:0] weight = 4'd0;

    logic [7:0] v_u, v_s;
    logic       sat_u, sat_s, busy_u, busy_s, done_u, done_s;

    always #5 clk = ~clk;

    // Unsigned with leak (defaults) and signed without leak share all inputs.
    syn_accum_unit u_dut (
        .clk(clk), .rst(rst), .clr(clr), .step_start(step_start),
        .step_end(step_end), .syn_en(syn_en), .weight(weight),
        .cur_voltage(v_u), .sat(sat_u), .busy(busy_u), .done(done_u)
    );

    syn_accum_unit #(.SIGNED_W(1), .LEAK_SHIFT(0), .V_REST(8'h88)) s_dut (
        .clk(clk), .rst(rst), .clr(clr), .step_start(step_start),
        .step_end(step_end), .syn_en(syn_en), .weight(weight),
        .cur_voltage(v_s), .sat(sat_s), .busy(busy_s), .done(done_s)
    );

    typedef struct {
        int v;
        bit s;
        int busy_cycles;
    } exp_t;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q_exp[2][$];
    int   m_v[2];
    bit   m_sat[2];
    logic [4:0] spikes[$];   // {en, weight} per ACCU cycle
    int   bc[2];

    function automatic logic [7:0] lo8(input int x);
        logic [31:0] t;
        t = x;
        return t[7:0];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: integer add then clamp to the format's range.
    function automatic void model_add(input int d, input logic [4:0] sp);
        int w, lo, hi, x;
        logic [3:0] wb;
        if (!sp[4]) return;
        wb = sp[3:0];
        w  = (d == 1) ? int'($signed(wb)) : int'(wb);
        lo = (d == 1) ? -128 : 0;
        hi = (d == 1) ? 127 : 255;
        x  = m_v[d] + w;
        if (x > hi) begin x = hi; m_sat[d] = 1'b1; end
        if (x < lo) begin x = lo; m_sat[d] = 1'b1; end
        m_v[d] = x;
    endfunction

    task automatic on_done(input int d, input logic [7:0] v, input logic s, input int b);
        exp_t e;
        if (q_exp[d].size() == 0) begin
            check($sformatf("unexpected_done_dut%0d", d), 1, 0);
        end else begin
            e = q_exp[d].pop_front();
            check($sformatf("final_v_dut%0d", d), int'(v), int'(lo8(e.v)));
            check($sformatf("final_sat_dut%0d", d), int'(s), int'(e.s));
            check($sformatf("busy_cycles_dut%0d", d), b, e.busy_cycles);
        end
    endtask

    // Monitors: count busy cycles, compare on every done pulse.
    always @(negedge clk) begin
        if (!rst) bc[0] = 0;
        else begin
            if (busy_u) bc[0]++; else bc[0] = 0;
            if (done_u) on_done(0, v_u, sat_u, bc[0]);
        end
    end

    always @(negedge clk) begin
        if (!rst) bc[1] = 0;
        else begin
            if (busy_s) bc[1]++; else bc[1] = 0;
            if (done_s) on_done(1, v_s, sat_s, bc[1]);
        end
    end

    task automatic check_state(input string tag, input bit exp_busy);
        check({tag, "_v_u"}, int'(v_u), int'(lo8(m_v[0])));
        check({tag, "_v_s"}, int'(v_s), int'(lo8(m_v[1])));
        check({tag, "_sat_u"}, int'(sat_u), int'(m_sat[0]));
        check({tag, "_sat_s"}, int'(sat_s), int'(m_sat[1]));
        check({tag, "_busy"}, int'({busy_u, busy_s}), exp_busy ? 3 : 0);
    endtask

    task automatic do_clr();
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        m_v[0] = 0; m_v[1] = -120;
        m_sat[0] = 1'b0; m_sat[1] = 1'b0;
        @(negedge clk);
        check_state("clr", 1'b0);
    endtask

    // One timestep driven from the spikes queue; optional clr during DECAY.
    task automatic run_step(input bit clr_decay);
        int  n;
        bit  idle;
        n = spikes.size();
        @(posedge clk); #1;
        step_start = 1'b1;
        syn_en     = 1'($urandom % 2);   // ignored in IDLE
        weight     = 4'($urandom);
        step_end   = 1'($urandom % 2);   // ignored in IDLE
        m_sat[0] = 1'b0; m_sat[1] = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            syn_en     = spikes[k][4];
            weight     = spikes[k][3:0];
            step_end   = (k == n - 1);
            step_start = 1'($urandom % 2); // ignored outside IDLE
            if (k >= 2) begin
                model_add(0, spikes[k-2]);
                model_add(1, spikes[k-2]);
            end
            @(negedge clk);
            check_state("accu", 1'b1);
            @(posedge clk); #1;
        end
        // Now in DRAIN: the remaining spikes retire, then leak on the unsigned unit.
        for (int k = (n >= 2 ? n - 2 : 0); k < n; k++) begin
            model_add(0, spikes[k]);
            model_add(1, spikes[k]);
        end
        q_exp[1].push_back('{m_v[1], m_sat[1], n + 2});
        if (!clr_decay) begin
            m_v[0] = m_v[0] - (m_v[0] >>> 1);
            q_exp[0].push_back('{m_v[0], m_sat[0], n + 3});
        end
        syn_en     = 1'($urandom % 2);
        weight     = 4'($urandom);
        step_start = 1'($urandom % 2);
        step_end   = 1'($urandom % 2);
        @(posedge clk); #1;
        step_start = 1'b0;
        syn_en     = 1'($urandom % 2);
        weight     = 4'($urandom);
        step_end   = 1'($urandom % 2);
        clr        = clr_decay;
        @(posedge clk); #1;
        clr = 1'b0;
        if (clr_decay) begin
            m_v[0] = 0; m_v[1] = -120;
            m_sat[0] = 1'b0; m_sat[1] = 1'b0;
            @(negedge clk);
            check_state("clr_decay", 1'b0);
        end
        idle = 1'b0;
        for (int i = 0; i < 8 && !idle; i++) begin
            @(negedge clk);
            if (!busy_u && !busy_s) idle = 1'b1;
        end
        if (!idle) check("step_return_idle", 0, 1);
        syn_en = 1'b0; step_end = 1'b0; step_start = 1'b0;
    endtask

    // Idle cycles with stray step_end/syn_en that must change nothing.
    task automatic idle_noise(input int c);
        for (int i = 0; i < c; i++) begin
            @(posedge clk); #1;
            syn_en   = 1'($urandom % 2);
            weight   = 4'($urandom);
            step_end = 1'($urandom % 2);
            @(negedge clk);
            check_state("idle", 1'b0);
        end
        syn_en = 1'b0; step_end = 1'b0;
    endtask

    task automatic fill_random();
        int n;
        spikes.delete();
        n = $urandom_range(1, 12);
        for (int i = 0; i < n; i++) begin
            spikes.push_back({1'($urandom % 10 < 7), 4'($urandom)});
        end
    endtask

    task automatic reset_mid();
        @(posedge clk); #1;
        step_start = 1'b1;
        @(posedge clk); #1;
        step_start = 1'b0; syn_en = 1'b1; weight = 4'd5;
        @(posedge clk); #1;
        weight = 4'd6;
        #2;
        rst = 1'b0; syn_en = 1'b0;
        #1;
        check("rst_async_v_u", int'(v_u), 0);
        check("rst_async_v_s", int'(v_s), 0);
        check("rst_async_sat", int'({sat_u, sat_s}), 0);
        check("rst_async_busy", int'({busy_u, busy_s}), 0);
        check("rst_async_done", int'({done_u, done_s}), 0);
        #2;
        rst = 1'b1;
        m_v[0] = 0; m_v[1] = 0;
        m_sat[0] = 1'b0; m_sat[1] = 1'b0;
        @(negedge clk);
        check_state("after_rst", 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        check("reset_v_u", int'(v_u), 0);
        check("reset_v_s", int'(v_s), 0);
        check("reset_flags", int'({sat_u, sat_s, busy_u, busy_s, done_u, done_s}), 0);
        #1 rst = 1'b1;

        // Signed: from -120 add -8, -8 (clamps), +7.
        do_clr();
        spikes = '{5'h18, 5'h18, 5'h17};
        run_step(1'b0);

        // Back-to-back 3, 5, 7 with step_end on the last spike.
        do_clr();
        spikes = '{5'h13, 5'h15, 5'h17};
        run_step(1'b0);

        // Drive the unsigned unit into saturation, then a fresh step clears sat.
        do_clr();
        spikes.delete();
        for (int i = 0; i < 20; i++) spikes.push_back(5'h1F);
        run_step(1'b0);
        fill_random();
        run_step(1'b0);
        idle_noise(6);

        for (int s = 0; s < 40; s++) begin
            fill_random();
            run_step(1'b0);
            if ($urandom % 4 == 0) idle_noise(3);
        end

        reset_mid();
        for (int s = 0; s < 5; s++) begin
            fill_random();
            run_step(1'b0);
        end

        fill_random();
        run_step(1'b1);
        idle_noise(3);
        for (int s = 0; s < 5; s++) begin
            fill_random();
            run_step(1'b0);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pending_dut0", q_exp[0].size(), 0);
        check("pending_dut1", q_exp[1].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
